hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller generating the stall/flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC unit. Detects load-use hazards between the ID and EX stages, applies control-flow redirect flushes from EX, and freezes the pipeline while a data-memory access in MEM waits for ready. Holds a small FSM for memory wait, deferred redirect and a watchdog; sits beside the five pipeline registers in the core top level.

## Interface
- `RF_SIZE`, 5: register-index width.
- `WDOG_W`, 8: memory-wait watchdog counter width.
- `WDOG_LIMIT`, 200: wait cycles before `wdog_err_o` sets.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `id_rs1_i`, `id_rs2_i` in RF_SIZE: source indices of the instruction in ID.
- `id_ers1_i`, `id_ers2_i` in 1: source-read enables in ID.
- `ex_rd_i` in RF_SIZE: destination index held in ID/EX.
- `ex_erd_i`, `ex_ememread_i` in 1: ID/EX write-enable and load flag.
- `ex_redirect_i` in 1: EX resolves a taken branch, jal or jalr.
- `mem_req_i` in 1: MEM stage has a load/store in flight.
- `mem_ready_i` in 1: data memory completes the access this cycle.
- `pc_stall_o`, `ifid_stall_o`, `ifid_flush_o`, `idex_stall_o`, `idex_flush_o`, `exmem_stall_o`, `memwb_flush_o` out 1: per-register controls.
- `pc_redirect_o` out 1: PC unit loads the EX target this cycle.
- `wdog_err_o` out 1: sticky memory-timeout error.

## Operation
- FSM states: RUN, MEMWAIT, REPLAY.
- RUN → MEMWAIT when `mem_req_i && !mem_ready_i`; MEMWAIT → REPLAY on `mem_ready_i` when `redirect_pend` is set, otherwise MEMWAIT → RUN; REPLAY → RUN unconditionally after one cycle.
- Combinational controls, priority highest first:
  - Memory wait (`mem_req_i && !mem_ready_i`, any state): assert pc/ifid/idex/exmem stall and `memwb_flush_o`; no flushes forwarded upstream; `ex_redirect_i` sets `redirect_pend`.
  - REPLAY: `pc_redirect_o`, `ifid_flush_o`, `idex_flush_o`; clear `redirect_pend`.
  - Redirect in RUN (`ex_redirect_i`): `pc_redirect_o`, `ifid_flush_o`, `idex_flush_o`.
  - Load-use in RUN: `ex_ememread_i && ex_erd_i && ex_rd_i != 0 && ((id_ers1_i && id_rs1_i == ex_rd_i) || (id_ers2_i && id_rs2_i == ex_rd_i))` → `pc_stall_o`, `ifid_stall_o`, `idex_flush_o` (one bubble).
- Redirect wins over a simultaneous load-use: only redirect controls assert.
- Register x0 never produces a load-use hazard.
- Watchdog: counter increments each MEMWAIT cycle, saturates at `WDOG_LIMIT`; cleared on MEMWAIT exit; `wdog_err_o` sets at the limit and holds until reset.

## Timing
- All stall/flush/redirect outputs are combinational from inputs and current state; no added latency.
- Load-use: exactly one bubble; next cycle the ID/EX load flag is 0 and the hazard clears.
- Memory wait of N cycles freezes upstream for N cycles; release in the `mem_ready_i` cycle.
- Deferred redirect takes effect in the single REPLAY cycle after release.
- Reset: state RUN, `redirect_pend` 0, watchdog 0, `wdog_err_o` 0; all outputs 0 while reset asserted. Reset mid-MEMWAIT discards the pending redirect.

## Configuration
- `HAZARD_PERF_EN`: when defined, adds outputs `perf_stall_o` (32 bit, counts cycles with `pc_stall_o`) and `perf_flush_o` (32 bit, counts cycles with `idex_flush_o`), both wrapping, reset to 0. When undefined, the ports and counters are absent; all other behaviour identical.

## Structure
- Shared package: FSM state enumeration (RUN/MEMWAIT/REPLAY), `RF_SIZE` default, watchdog default limit.
- One sub-module: `hazard_wdog` (saturating counter plus sticky error flag).

## Test plan
- ID/EX holds a load to x5, ID reads x5 via rs2 → exactly one cycle of `pc_stall_o`=`ifid_stall_o`=`idex_flush_o`=1, then all 0.
- Load to x0, ID reads x0 → no stall.
- `ex_redirect_i` together with a load-use match → `pc_redirect_o`, `ifid_flush_o`, `idex_flush_o`=1, `pc_stall_o`=0.
- `mem_req_i`=1, `mem_ready_i` low 3 cycles with `ex_redirect_i`=1 → 3 cycles of full freeze with `memwb_flush_o`, then the ready cycle, then one REPLAY cycle with redirect and flushes.
- `mem_ready_i` held low 200 cycles → `wdog_err_o` rises and stays high after ready; `rst_i` pulsed mid-wait → state RUN, error cleared.
- With `HAZARD_PERF_EN`: 2 load-use events and 1 redirect → `perf_stall_o`=2, `perf_flush_o`=3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_t       : controller FSM states (RUN / MEMWAIT / REPLAY)
//   - RF_SIZE_DEF      : default register-index width
//   - WDOG_W_DEF       : default memory-wait watchdog counter width
//   - WDOG_LIMIT_DEF   : default watchdog limit in wait cycles
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_REPLAY  = 2'd2
    } hz_state_t;

    localparam int RF_SIZE_DEF    = 5;
    localparam int WDOG_W_DEF     = 8;
    localparam int WDOG_LIMIT_DEF = 200;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// hazard_wdog
// Saturating memory-wait watchdog with a sticky error flag.
// Ports:
//   clk_i    in  : clock, rising edge
//   rst_i    in  : asynchronous active-high reset (clears counter and error)
//   wait_i   in  : 1 in every cycle the data memory access is still waiting
//   err_o    out : sticky timeout error, set once WDOG_LIMIT wait cycles
//                  have been counted in one uninterrupted wait
// The counter clears in any cycle without a wait; the error only clears on
// reset.
// -----------------------------------------------------------------------------
module hazard_wdog
    import hazard_ctrl_pkg::*;
#(
    parameter int WDOG_W     = WDOG_W_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    output logic err_o
);

    localparam logic [WDOG_W-1:0] LIMIT    = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] LIMIT_M1 = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] r_cnt;
    logic              r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!wait_i) begin
                r_cnt <= '0;
            end else if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Error rises on the same edge the counter reaches the limit.
            if (wait_i && (r_cnt >= LIMIT_M1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;

endmodule : hazard_wdog

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: stall/flush controls for IF/ID, ID/EX, EX/MEM,
// MEM/WB and the PC unit. Handles load-use bubbles, EX redirects, and freezes
// the pipe while a MEM access waits for ready (redirects seen during the
// freeze are deferred and replayed in one REPLAY cycle after release).
// Optional feature macro: HAZARD_PERF_EN (adds perf_stall_o / perf_flush_o).
// Ports:
//   clk_i, rst_i                  : clock, async active-high reset
//   id_rs1_i/id_rs2_i, id_ers*_i  : ID source indices and read enables
//   ex_rd_i, ex_erd_i             : ID/EX destination index and write enable
//   ex_ememread_i                 : ID/EX holds a load
//   ex_redirect_i                 : EX resolved a taken control transfer
//   mem_req_i, mem_ready_i        : MEM access in flight / completes now
//   pc/ifid/idex/exmem stall, ifid/idex/memwb flush, pc_redirect_o : controls
//   wdog_err_o                    : sticky memory-timeout error
//   perf_stall_o, perf_flush_o    : (HAZARD_PERF_EN only) wrapping counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RF_SIZE    = RF_SIZE_DEF,
    parameter int WDOG_W     = WDOG_W_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [RF_SIZE-1:0] id_rs1_i,
    input  logic [RF_SIZE-1:0] id_rs2_i,
    input  logic               id_ers1_i,
    input  logic               id_ers2_i,
    input  logic [RF_SIZE-1:0] ex_rd_i,
    input  logic               ex_erd_i,
    input  logic               ex_ememread_i,
    input  logic               ex_redirect_i,
    input  logic               mem_req_i,
    input  logic               mem_ready_i,
    output logic               pc_stall_o,
    output logic               ifid_stall_o,
    output logic               ifid_flush_o,
    output logic               idex_stall_o,
    output logic               idex_flush_o,
    output logic               exmem_stall_o,
    output logic               memwb_flush_o,
    output logic               pc_redirect_o,
    output logic               wdog_err_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_o,
    output logic [31:0]        perf_flush_o
`endif
);

    hz_state_t r_state;
    hz_state_t w_state_next;
    logic      r_pend;
    logic      w_pend_next;

    logic w_memwait;
    logic w_load_use;

    logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
    logic w_idex_flush, w_exmem_stall, w_memwb_flush, w_pc_redirect;

    assign w_memwait = mem_req_i && !mem_ready_i;

    // x0 is hard-wired, so a load "to x0" never creates a dependency.
    assign w_load_use = ex_ememread_i && ex_erd_i && (ex_rd_i != '0) &&
                        ((id_ers1_i && (id_rs1_i == ex_rd_i)) ||
                         (id_ers2_i && (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pend_next   = r_pend;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_flush = 1'b0;
        w_pc_redirect = 1'b0;

        if (w_memwait) begin
            // Full freeze; a redirect from the frozen EX stage is remembered
            // rather than acted on, since IF/ID and ID/EX must hold.
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
            if (ex_redirect_i) begin
                w_pend_next = 1'b1;
            end
        end else if (r_state == ST_REPLAY) begin
            w_pc_redirect = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_pend_next   = 1'b0;
        end else if ((r_state == ST_RUN) && ex_redirect_i) begin
            w_pc_redirect = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
        end else if ((r_state == ST_RUN) && w_load_use) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
        end

        unique case (r_state)
            ST_RUN: begin
                if (w_memwait) begin
                    w_state_next = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready_i) begin
                    w_state_next = r_pend ? ST_REPLAY : ST_RUN;
                end
            end
            ST_REPLAY: begin
                // A new wait starting in the replay cycle suppresses the
                // replay; the pending flag survives and replays after it.
                w_state_next = w_memwait ? ST_MEMWAIT : ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Controls are forced low for the whole time reset is held.
    assign pc_stall_o    = w_pc_stall    && !rst_i;
    assign ifid_stall_o  = w_ifid_stall  && !rst_i;
    assign ifid_flush_o  = w_ifid_flush  && !rst_i;
    assign idex_stall_o  = w_idex_stall  && !rst_i;
    assign idex_flush_o  = w_idex_flush  && !rst_i;
    assign exmem_stall_o = w_exmem_stall && !rst_i;
    assign memwb_flush_o = w_memwb_flush && !rst_i;
    assign pc_redirect_o = w_pc_redirect && !rst_i;

    hazard_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wait_i (w_memwait),
        .err_o  (wdog_err_o)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (pc_stall_o) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (idex_flush_o) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_o = r_perf_stall;
    assign perf_flush_o = r_perf_flush;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed, table-driven bench for hazard_ctrl. Output vector bit order:
// {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
//  memwb_flush, pc_redirect}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] LU     = 8'b1100_1000;
    localparam logic [7:0] REDIR  = 8'b0010_1001;
    localparam logic [7:0] FREEZE = 8'b1101_0110;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_ers1_i, id_ers2_i, ex_erd_i, ex_ememread_i;
    logic       ex_redirect_i, mem_req_i, mem_ready_i;
    logic       pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o;
    logic       idex_flush_o, exmem_stall_o, memwb_flush_o, pc_redirect_o;
    logic       wdog_err_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_o, perf_flush_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_ers1_i     (id_ers1_i),
        .id_ers2_i     (id_ers2_i),
        .ex_rd_i       (ex_rd_i),
        .ex_erd_i      (ex_erd_i),
        .ex_ememread_i (ex_ememread_i),
        .ex_redirect_i (ex_redirect_i),
        .mem_req_i     (mem_req_i),
        .mem_ready_i   (mem_ready_i),
        .pc_stall_o    (pc_stall_o),
        .ifid_stall_o  (ifid_stall_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_stall_o  (idex_stall_o),
        .idex_flush_o  (idex_flush_o),
        .exmem_stall_o (exmem_stall_o),
        .memwb_flush_o (memwb_flush_o),
        .pc_redirect_o (pc_redirect_o),
        .wdog_err_o    (wdog_err_o)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_o  (perf_stall_o),
        .perf_flush_o  (perf_flush_o)
`endif
    );

    wire [7:0] w_outs = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                         idex_flush_o, exmem_stall_o, memwb_flush_o, pc_redirect_o};

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       ers1, ers2, erd, ld, redir, req, rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs1, input logic ers1,
                                input logic [4:0] rs2, input logic ers2,
                                input logic [4:0] rd, input logic erd,
                                input logic ld, input logic redir,
                                input logic req, input logic rdy,
                                input logic [7:0] exp);
        vec_t v;
        v.rs1 = rs1; v.ers1 = ers1; v.rs2 = rs2; v.ers2 = ers2;
        v.rd = rd; v.erd = erd; v.ld = ld; v.redir = redir;
        v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1_i = v.rs1; id_ers1_i = v.ers1;
        id_rs2_i = v.rs2; id_ers2_i = v.ers2;
        ex_rd_i = v.rd; ex_erd_i = v.erd; ex_ememread_i = v.ld;
        ex_redirect_i = v.redir; mem_req_i = v.req; mem_ready_i = v.rdy;
    endtask

    // One cycle: change inputs just after the rising edge, sample at falling.
    task automatic step(input vec_t v);
        @(posedge clk_i);
        #1;
        drive(v);
        @(negedge clk_i);
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: outputs %b", name, got);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: value %b", name, got);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: count %0d", name, got);
        end
    endtask
`endif

    initial begin
        vec_t idle, wait_r, wait_n, ready, lu5;
        //           rs1 e1  rs2 e2  rd  erd ld  rdr req rdy exp
        idle   = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, NONE);
        wait_r = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, FREEZE);
        wait_n = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, FREEZE);
        ready  = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, NONE);
        lu5    = mk(5'd1, 1, 5'd5, 1, 5'd5, 1, 1, 0, 0, 0, LU);

        vecs[0]  = idle;
        vecs[1]  = lu5;                                                      // load x5, rs2 = x5
        vecs[2]  = mk(5'd1, 1, 5'd5, 1, 5'd5, 1, 0, 0, 0, 0, NONE);          // bubble: no load in EX
        vecs[3]  = mk(5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0, NONE);          // load x0
        vecs[4]  = mk(5'd5, 0, 5'd2, 1, 5'd5, 1, 1, 0, 0, 0, NONE);          // rs1 match, not read
        vecs[5]  = mk(5'd7, 1, 5'd2, 0, 5'd7, 1, 1, 0, 0, 0, LU);            // rs1 match
        vecs[6]  = mk(5'd7, 1, 5'd2, 0, 5'd7, 0, 1, 0, 0, 0, NONE);          // load without write
        vecs[7]  = mk(5'd1, 1, 5'd5, 1, 5'd5, 1, 1, 1, 0, 0, REDIR);         // redirect beats load-use
        vecs[8]  = mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, REDIR);         // plain redirect
        vecs[9]  = mk(5'd1, 1, 5'd5, 1, 5'd5, 1, 1, 0, 1, 1, LU);            // mem ready: no wait
        vecs[10] = mk(5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0, NONE);          // ALU producer
        vecs[11] = mk(5'd6, 1, 5'd6, 1, 5'd5, 1, 1, 0, 0, 0, NONE);          // index mismatch

        // Reset held with hazardous inputs: every control must stay low.
        rst_i = 1'b1;
        drive(mk(5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1, 1, 0, NONE));
        @(negedge clk_i);
        chk8("reset_outputs", w_outs, NONE);
        chk1("reset_wdog", wdog_err_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(idle);
        @(negedge clk_i);

`ifdef HAZARD_PERF_EN
        step(lu5);
        step(idle);
        step(lu5);
        step(vecs[8]);
        step(idle);
        chk32("perf_stall", perf_stall_o, 32'd2);
        chk32("perf_flush", perf_flush_o, 32'd3);
`endif

        for (int i = 0; i < 12; i++) begin
            step(vecs[i]);
            chk8($sformatf("vec%0d", i), w_outs, vecs[i].exp);
        end

        // Memory wait of 3 cycles with a redirect in EX, then replay.
        for (int i = 0; i < 3; i++) begin
            step(wait_r);
            chk8($sformatf("memwait_redir_c%0d", i), w_outs, FREEZE);
        end
        step(mk(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 1, NONE));
        chk8("memwait_release", w_outs, NONE);
        step(idle);
        chk8("replay_cycle", w_outs, REDIR);
        step(idle);
        chk8("after_replay", w_outs, NONE);

        // Wait without redirect: release then straight back to RUN.
        step(wait_n);
        chk8("memwait_plain_c0", w_outs, FREEZE);
        step(wait_n);
        chk8("memwait_plain_c1", w_outs, FREEZE);
        step(ready);
        chk8("memwait_plain_release", w_outs, NONE);
        step(idle);
        chk8("no_replay", w_outs, NONE);
        step(lu5);
        chk8("run_loaduse_after_wait", w_outs, LU);

        // Watchdog boundary: 199 counted wait cycles -> clear, 200 -> set.
        for (int i = 0; i < 200; i++) begin
            step(wait_n);
        end
        chk1("wdog_before_limit", wdog_err_o, 1'b0);
        step(wait_n);
        chk1("wdog_at_limit", wdog_err_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(wait_n);
        end
        step(ready);
        chk8("wdog_release", w_outs, NONE);
        step(idle);
        chk1("wdog_sticky", wdog_err_o, 1'b1);

        // Reset mid-wait with a pending redirect: all cleared, no replay.
        step(wait_r);
        step(wait_r);
        chk8("pre_reset_freeze", w_outs, FREEZE);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk8("midwait_reset_outputs", w_outs, NONE);
        chk1("midwait_reset_wdog", wdog_err_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(idle);
        @(negedge clk_i);
        chk8("post_reset_no_replay", w_outs, NONE);
        step(vecs[8]);
        chk8("post_reset_run_redirect", w_outs, REDIR);
        chk1("post_reset_wdog", wdog_err_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
